cu_state_sequencer: RTL and testbench

- State-holding, output-generating half of the multi-cycle CPU control unit.
- Registers the next-state value produced by the control unit's combinational next-state logic.
- Presents the current state back to that logic and decodes it, together with Opcode, into per-cycle datapath strobes.
- Adds a data-memory ready stall, a sticky HALT state and illegal-state recovery.

---
 rtl/cu_pkg.sv | 40 ++++
 rtl/cu_state_sequencer_if.sv | 29 ++
 rtl/cu_strobe_decode.sv | 41 ++++
 rtl/cu_state_sequencer.sv | 87 ++++++++
 tb/tb_cu_state_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared control-unit definitions: state encodings, opcode constants and the strobe bundle.
// Imported by the sequencer, its strobe decoder and the next-state logic.
package cu_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE    = 3'b010,
    S_MEM_WB = 3'b011,
    S_HALT   = 3'b100
  } state_e;

  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b110100;

  typedef struct packed {
    logic ins_mem_rw;
    logic ir_wre;
    logic pc_wre;
    logic reg_wre;
    logic m_rd;
    logic m_wr;
    logic halted;
  } strobes_t;

  // Codes above S_HALT are unused encodings and must never be entered.
  function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
    return (s <= S_HALT);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cu_state_sequencer_if.sv
// Signal bundle between the control unit's next-state logic (master) and the state sequencer (slave).
// mem_ready acts as the data-memory ready: a MEM_WB access completes on the rising edge where it is high.
interface cu_seq_if;
  import cu_pkg::*;

  logic [STATE_W-1:0] n_state;
  logic [5:0]         Opcode;
  logic               mem_ready;
  logic [STATE_W-1:0] cur_state;
  logic               InsMemRW;
  logic               IRWre;
  logic               PCWre;
  logic               RegWre;
  logic               mRD;
  logic               mWR;
  logic               halted;
  logic               state_err;

  modport master (
    output n_state, Opcode, mem_ready,
    input  cur_state, InsMemRW, IRWre, PCWre, RegWre, mRD, mWR, halted, state_err
  );

  modport slave (
    input  n_state, Opcode, mem_ready,
    output cur_state, InsMemRW, IRWre, PCWre, RegWre, mRD, mWR, halted, state_err
  );

endinterface

// File: rtl/cu_strobe_decode.sv
// Purely combinational decode of current state, opcode and stall into per-cycle datapath strobes.
module cu_strobe_decode
  import cu_pkg::*;
(
  input  state_e     cur_state_i,
  input  logic [5:0] opcode_i,
  input  logic       stall_i,
  output strobes_t   strobes_o
);

  always_comb begin
    strobes_o = '0;
    case (cur_state_i)
      S_IF: begin
        strobes_o.ins_mem_rw = 1'b1;
        strobes_o.ir_wre     = 1'b1;
      end
      S_ID: begin
        strobes_o.pc_wre = (opcode_i == OP_J);
      end
      S_EXE: begin
        strobes_o = '0;
      end
      S_MEM_WB: begin
        // Memory strobes stay up across a stall; writeback and PC update wait for mem_ready.
        strobes_o.m_rd    = (opcode_i == OP_LW);
        strobes_o.m_wr    = (opcode_i == OP_SW);
        strobes_o.reg_wre = !stall_i && !((opcode_i == OP_SW) || (opcode_i == OP_BEQ) ||
                                          (opcode_i == OP_J));
        strobes_o.pc_wre  = !stall_i;
      end
      S_HALT: begin
        strobes_o.halted = 1'b1;
      end
      default: begin
        strobes_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/cu_state_sequencer.sv
// Multi-cycle control unit state register with memory stall, sticky HALT and illegal-state recovery.
// Optional retired-instruction counter enabled by defining CU_RETIRE_CNT_EN.
module cu_state_sequencer
  import cu_pkg::*;
`ifdef CU_RETIRE_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic             CLK,
  input  logic             Reset,
  cu_seq_if.slave          bus
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  state_e   state_q, state_d;
  logic     err_q, err_d;
  logic     stall;
  strobes_t strobes;

  assign stall = (state_q == S_MEM_WB) && is_mem_op(bus.Opcode) && !bus.mem_ready;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Priority: sticky HALT, HALT opcode in ID, memory stall, illegal target, then n_state.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if ((state_q == S_ID) && (bus.Opcode == OP_HALT)) begin
      state_d = S_HALT;
    end else if (stall) begin
      state_d = state_q;
    end else if (!is_legal_state(bus.n_state)) begin
      state_d = S_IF;
      err_d   = 1'b1;
    end else begin
      state_d = state_e'(bus.n_state);
    end
  end

  cu_strobe_decode u_decode (
    .cur_state_i (state_q),
    .opcode_i    (bus.Opcode),
    .stall_i     (stall),
    .strobes_o   (strobes)
  );

  assign bus.cur_state = state_q;
  assign bus.InsMemRW  = strobes.ins_mem_rw;
  assign bus.IRWre     = strobes.ir_wre;
  assign bus.PCWre     = strobes.pc_wre;
  assign bus.RegWre    = strobes.reg_wre;
  assign bus.mRD       = strobes.m_rd;
  assign bus.mWR       = strobes.m_wr;
  assign bus.halted    = strobes.halted;
  assign bus.state_err = err_q;

`ifdef CU_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  // PCWre is never raised in HALT, so the count freezes there without an extra term.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      retired_q <= '0;
    end else if (strobes.pc_wre) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_cu_state_sequencer.sv
// Self-checking bench for cu_state_sequencer: vector table, corner-case sequences, random run vs model.
module tb_cu_state_sequencer;

  localparam logic [5:0] T_J    = 6'b111000;
  localparam logic [5:0] T_HALT = 6'b111111;
  localparam logic [5:0] T_LW   = 6'b100111;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b110100;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  cu_seq_if bus ();

`ifdef CU_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  cu_state_sequencer dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
`ifdef CU_RETIRE_CNT_EN
    ,
    .retired (retired)
`endif
  );

  // strobe order: InsMemRW, IRWre, PCWre, RegWre, mRD, mWR, halted
  logic [6:0] dut_strb;
  assign dut_strb = {bus.InsMemRW, bus.IRWre, bus.PCWre, bus.RegWre, bus.mRD, bus.mWR, bus.halted};

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  int          m_state;    // 0=IF 1=ID 2=EXE 3=MEM_WB 4=HALT
  logic        m_err;
  logic [31:0] m_retired;

  function automatic logic [6:0] exp_strobes(input int st, input logic [5:0] op, input logic mr);
    logic waiting, writes;
    waiting = ((op == T_LW) || (op == T_SW)) && !mr;
    writes  = !((op == T_SW) || (op == T_BEQ) || (op == T_J));
    case (st)
      0: return 7'b1100000;
      1: return (op == T_J) ? 7'b0010000 : 7'b0000000;
      3: return {2'b00, !waiting, writes && !waiting, op == T_LW, op == T_SW, 1'b0};
      4: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    m_state   = 0;
    m_err     = 1'b0;
    m_retired = 32'd0;
  endtask

  task automatic model_edge(input logic [2:0] n, input logic [5:0] op, input logic mr);
    logic [6:0] s;
    s = exp_strobes(m_state, op, mr);
    if (s[4]) m_retired = m_retired + 32'd1;
    m_err = 1'b0;
    if (m_state == 4) m_state = 4;
    else if (m_state == 1 && op == T_HALT) m_state = 4;
    else if (m_state == 3 && (op == T_LW || op == T_SW) && !mr) m_state = 3;
    else if (int'(n) > 4) begin
      m_state = 0;
      m_err   = 1'b1;
    end else m_state = int'(n);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset = 1'b0;
    #3;
    model_reset();
    check("reset cur_state", 32'(bus.cur_state), 32'd0);
    check("reset strobes", 32'(dut_strb), 32'b1100000);
    check("reset state_err", 32'(bus.state_err), 32'd0);
`ifdef CU_RETIRE_CNT_EN
    check("reset retired", retired, 32'd0);
`endif
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic step(input logic [2:0] n, input logic [5:0] op, input logic mr, input string tag);
    bus.n_state   = n;
    bus.Opcode    = op;
    bus.mem_ready = mr;
    #1;
    check({tag, " strobes"}, 32'(dut_strb), 32'(exp_strobes(m_state, op, mr)));
    @(posedge CLK);
    model_edge(n, op, mr);
    #1;
    check({tag, " cur_state"}, 32'(bus.cur_state), 32'(m_state));
    check({tag, " state_err"}, 32'(bus.state_err), 32'(m_err));
`ifdef CU_RETIRE_CNT_EN
    check({tag, " retired"}, retired, m_retired);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] n;
    logic [5:0] op;
    logic       mr;
    logic [6:0] strb;
    logic [2:0] nxt;
    logic       err;
  } vec_t;

  vec_t vecs[28];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd1, 6'd0,  1'b1, 7'b1100000, 3'd1, 1'b0};
    vecs[1]  = '{3'd2, 6'd0,  1'b1, 7'b0000000, 3'd2, 1'b0};
    vecs[2]  = '{3'd3, 6'd0,  1'b1, 7'b0000000, 3'd3, 1'b0};
    vecs[3]  = '{3'd0, 6'd0,  1'b1, 7'b0011000, 3'd0, 1'b0};
    vecs[4]  = '{3'd1, T_LW,  1'b1, 7'b1100000, 3'd1, 1'b0};
    vecs[5]  = '{3'd2, T_LW,  1'b1, 7'b0000000, 3'd2, 1'b0};
    vecs[6]  = '{3'd3, T_LW,  1'b1, 7'b0000000, 3'd3, 1'b0};
    vecs[7]  = '{3'd0, T_LW,  1'b0, 7'b0000100, 3'd3, 1'b0};
    vecs[8]  = '{3'd0, T_LW,  1'b0, 7'b0000100, 3'd3, 1'b0};
    vecs[9]  = '{3'd0, T_LW,  1'b0, 7'b0000100, 3'd3, 1'b0};
    vecs[10] = '{3'd0, T_LW,  1'b1, 7'b0011100, 3'd0, 1'b0};
    vecs[11] = '{3'd1, T_J,   1'b1, 7'b1100000, 3'd1, 1'b0};
    vecs[12] = '{3'd0, T_J,   1'b1, 7'b0010000, 3'd0, 1'b0};
    vecs[13] = '{3'd1, 6'd0,  1'b1, 7'b1100000, 3'd1, 1'b0};
    vecs[14] = '{3'd2, 6'd0,  1'b1, 7'b0000000, 3'd2, 1'b0};
    vecs[15] = '{3'd6, 6'd0,  1'b1, 7'b0000000, 3'd0, 1'b1};
    vecs[16] = '{3'd1, 6'd0,  1'b1, 7'b1100000, 3'd1, 1'b0};
    vecs[17] = '{3'd2, 6'd0,  1'b1, 7'b0000000, 3'd2, 1'b0};
    vecs[18] = '{3'd3, 6'd0,  1'b1, 7'b0000000, 3'd3, 1'b0};
    vecs[19] = '{3'd0, 6'd0,  1'b0, 7'b0011000, 3'd0, 1'b0};
    vecs[20] = '{3'd1, T_BEQ, 1'b1, 7'b1100000, 3'd1, 1'b0};
    vecs[21] = '{3'd2, T_BEQ, 1'b1, 7'b0000000, 3'd2, 1'b0};
    vecs[22] = '{3'd3, T_BEQ, 1'b1, 7'b0000000, 3'd3, 1'b0};
    vecs[23] = '{3'd0, T_BEQ, 1'b0, 7'b0010000, 3'd0, 1'b0};
    vecs[24] = '{3'd1, T_SW,  1'b1, 7'b1100000, 3'd1, 1'b0};
    vecs[25] = '{3'd2, T_SW,  1'b1, 7'b0000000, 3'd2, 1'b0};
    vecs[26] = '{3'd3, T_SW,  1'b1, 7'b0000000, 3'd3, 1'b0};
    vecs[27] = '{3'd0, T_SW,  1'b1, 7'b0010010, 3'd0, 1'b0};

    bus.n_state   = 3'd0;
    bus.Opcode    = 6'd0;
    bus.mem_ready = 1'b1;
    model_reset();
    do_reset();

    // Table-driven directed vectors.
    for (int i = 0; i < 28; i++) begin
      bus.n_state   = vecs[i].n;
      bus.Opcode    = vecs[i].op;
      bus.mem_ready = vecs[i].mr;
      #1;
      check($sformatf("vec%0d strobes", i), 32'(dut_strb), 32'(vecs[i].strb));
      @(posedge CLK);
      model_edge(vecs[i].n, vecs[i].op, vecs[i].mr);
      #1;
      check($sformatf("vec%0d cur_state", i), 32'(bus.cur_state), 32'(vecs[i].nxt));
      check($sformatf("vec%0d state_err", i), 32'(bus.state_err), 32'(vecs[i].err));
`ifdef CU_RETIRE_CNT_EN
      check($sformatf("vec%0d retired", i), retired, m_retired);
`endif
    end

    // HALT is sticky regardless of n_state and opcode until reset.
    step(3'd1, T_HALT, 1'b1, "halt_if");
    step(3'd2, T_HALT, 1'b1, "halt_id");
    check("halt entered", 32'(bus.cur_state), 32'd4);
    for (int i = 0; i < 12; i++) begin
      step(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), "halt_hold");
      check("halt halted", 32'(bus.halted), 32'd1);
    end
    do_reset();

    // Asynchronous reset in a stalled SW MEM_WB cycle drops mWR without a clock edge.
    step(3'd1, T_SW, 1'b1, "async_if");
    step(3'd2, T_SW, 1'b1, "async_id");
    step(3'd3, T_SW, 1'b1, "async_exe");
    bus.n_state   = 3'd0;
    bus.mem_ready = 1'b0;
    #2;
    check("async mWR before", 32'(bus.mWR), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("async mWR after", 32'(bus.mWR), 32'd0);
    check("async cur_state", 32'(bus.cur_state), 32'd0);
    check("async RegWre", 32'(bus.RegWre), 32'd0);
    model_reset();
    @(negedge CLK);
    Reset = 1'b1;

`ifdef CU_RETIRE_CNT_EN
    for (int k = 0; k < 5; k++) begin
      step(3'd1, 6'd0, 1'b1, "ret_if");
      step(3'd2, 6'd0, 1'b1, "ret_id");
      step(3'd3, 6'd0, 1'b1, "ret_exe");
      step(3'd0, 6'd0, 1'b1, "ret_mw");
    end
    check("retired five", retired, 32'd5);
`endif

    // Randomized run against the model, with occasional resets to leave HALT.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 39) == 0) do_reset();
      case ($urandom_range(0, 6))
        0: op = 6'd0;
        1: op = T_LW;
        2: op = T_SW;
        3: op = T_BEQ;
        4: op = T_J;
        5: op = T_HALT;
        default: op = 6'($urandom_range(0, 63));
      endcase
      step(3'($urandom_range(0, 7)), op, 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
